// File: rtl/dispatcher_if.sv
// dispatcher_if: RAM read side and transmitter-FIFO side of the dispatcher.
// master = dispatcher, slave = RAM/transmitter environment.
interface dispatcher_if #(
   parameter int ADDRWIDTH = 14,
   parameter int NPORT     = 10
);
   logic [NPORT*10-1:0]  i_wptr;
   logic [NPORT-1:0]     i_full;
   logic                 i_grant;
   logic [7:0]           i_D;
   logic [ADDRWIDTH-1:0] o_addr;
   logic                 o_re;
   logic [7:0]           o_D;
   logic [NPORT-1:0]     o_write;
   logic [NPORT*10-1:0]  o_rptr;

   modport master (
      input  i_wptr, i_full, i_grant, i_D,
      output o_addr, o_re, o_D, o_write, o_rptr
   );

   modport slave (
      output i_wptr, i_full, i_grant, i_D,
      input  o_addr, o_re, o_D, o_write, o_rptr
   );
endinterface

// File: rtl/dispatcher.sv
// dispatcher: round-robin drain of the per-port RAM byte regions
// into the matching UART transmitter FIFOs.
module dispatcher #(
   parameter int ADDRWIDTH = 14,
   parameter int NPORT     = 10,
   parameter int REGION    = 1024
) (
   input logic          i_clk,
   input logic          i_rst,
   dispatcher_if.master bus
);
   localparam int OW = $clog2(REGION);

   typedef enum logic [1:0] {
      SCAN = 2'd0,
      READ = 2'd1,
      WAIT = 2'd2,
      PUSH = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [3:0]                sport_q, sport_d;
   logic [3:0]                port_q, port_d;
   logic [7:0]                data_q, data_d;
   logic [NPORT-1:0][OW-1:0]  rptr_q, rptr_d;
   logic [NPORT-1:0][OW-1:0]  wptr;

   logic                      found;
   logic [3:0]                pick;
   logic [4:0]                sum;
   logic [3:0]                idx;

   assign wptr = bus.i_wptr;

   // first eligible port starting at sport, wrapping modulo NPORT
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < NPORT; i++) begin
         sum = 5'(sport_q) + 5'(i);
         idx = (sum >= 5'(NPORT)) ? 4'(sum - 5'(NPORT))
                                  : sum[3:0];
         if (!found && (wptr[idx] != rptr_q[idx])
             && !bus.i_full[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= SCAN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SCAN: if (found) state_d = READ;
         READ: if (bus.i_grant) state_d = WAIT;
         WAIT: state_d = PUSH;
         PUSH: state_d = SCAN;
         default: state_d = SCAN;
      endcase
   end

   always_comb begin
      port_d  = port_q;
      data_d  = data_q;
      sport_d = sport_q;
      rptr_d  = rptr_q;
      unique case (state_q)
         SCAN: if (found) port_d = pick;
         WAIT: data_d = bus.i_D;
         PUSH: begin
            rptr_d[port_q] = rptr_q[port_q] + 1'b1;
            sport_d = (port_q == 4'(NPORT - 1)) ? 4'd0
                                                : port_q + 4'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         port_q  <= '0;
         data_q  <= '0;
         sport_q <= '0;
         rptr_q  <= '0;
      end else begin
         port_q  <= port_d;
         data_q  <= data_d;
         sport_q <= sport_d;
         rptr_q  <= rptr_d;
      end
   end

   // every output decodes registered state only
   always_comb begin
      bus.o_re    = (state_q == READ);
      bus.o_addr  = ADDRWIDTH'({port_q, rptr_q[port_q]});
      bus.o_D     = data_q;
      bus.o_write = '0;
      if (state_q == PUSH) begin
         bus.o_write = {{(NPORT-1){1'b0}}, 1'b1} << port_q;
      end
      bus.o_rptr  = rptr_q;
   end
endmodule

// File: tb/tb_dispatcher.sv
// tb_dispatcher: randomized RAM contents and pointer traffic checked
// against a transaction-level round-robin model.
module tb_dispatcher;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dispatcher_if #(.ADDRWIDTH(14), .NPORT(10)) bus ();

   dispatcher #(
      .ADDRWIDTH(14),
      .NPORT(10),
      .REGION(1024)
   ) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] ram [16384];
   logic [7:0] rd_q = 8'h00;
   assign bus.i_D = rd_q;

   logic [9:0] obs_w [$];
   logic [7:0] obs_d [$];
   int         obs_c [$];
   int         obs_a [$];
   int         exp_p [$];
   logic [7:0] exp_d [$];
   int         cyc = 0;

   logic [9:0] mw [10];
   logic [9:0] mr [10];
   logic [9:0] mfull;
   int         msport;

   // RAM: data one cycle after an accepted read
   always @(posedge clk) begin
      if (bus.o_re && bus.i_grant) begin
         rd_q <= ram[bus.o_addr];
         obs_a.push_back(int'(bus.o_addr));
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (bus.o_write != 10'd0) begin
         obs_w.push_back(bus.o_write);
         obs_d.push_back(bus.o_D);
         obs_c.push_back(cyc);
      end
   end

   task automatic pack();
      for (int k = 0; k < 10; k++) bus.i_wptr[10*k +: 10] = mw[k];
      bus.i_full = mfull;
   endtask

   function automatic logic [99:0] model_rptr();
      logic [99:0] r;
      for (int k = 0; k < 10; k++) r[10*k +: 10] = mr[k];
      return r;
   endfunction

   // Serve ports in round-robin order until none is eligible.
   task automatic predict();
      bit any;
      int k;
      do begin
         any = 1'b0;
         for (int i = 0; i < 10; i++) begin
            k = (msport + i) % 10;
            if (!any && mw[k] != mr[k] && !mfull[k]) begin
               any = 1'b1;
               exp_p.push_back(k);
               exp_d.push_back(ram[k*1024 + int'(mr[k])]);
               mr[k] = mr[k] + 10'd1;
               msport = (k + 1) % 10;
            end
         end
      end while (any);
   endtask

   task automatic clear_obs();
      obs_w.delete(); obs_d.delete(); obs_c.delete();
      exp_p.delete(); exp_d.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 10; k++) begin mw[k] = '0; mr[k] = '0; end
      mfull = '0;
      msport = 0;
      bus.i_grant = 1'b1;
      pack();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
      obs_a.delete();
   endtask

   task automatic run_batch(input string name, input bit rg,
                            input int budget, input int gap);
      int n, t, m;
      predict();
      n = exp_p.size();
      t = 0;
      while (obs_w.size() < n && t < budget) begin
         @(negedge clk);
         if (rg) bus.i_grant = 1'($urandom_range(0, 1));
         t++;
      end
      bus.i_grant = 1'b1;
      repeat (8) @(negedge clk);
      n_checks++;
      if (obs_w.size() != n)
         $display("FAIL %s count: got %0d pulses, want %0d",
                  name, obs_w.size(), n);
      else n_pass++;
      m = (obs_w.size() < n) ? obs_w.size() : n;
      for (int i = 0; i < m; i++) begin
         n_checks++;
         if (obs_w[i] !== (10'b1 << exp_p[i]) || obs_d[i] !== exp_d[i])
            $display("FAIL %s pulse %0d: got w=%b d=%h, want port %0d d=%h",
                     name, i, obs_w[i], obs_d[i], exp_p[i], exp_d[i]);
         else n_pass++;
      end
      if (gap > 0) begin
         for (int i = 1; i < m; i++) begin
            n_checks++;
            if (obs_c[i] - obs_c[i-1] != gap)
               $display("FAIL %s gap %0d: got %0d, want %0d",
                        name, i, obs_c[i] - obs_c[i-1], gap);
            else n_pass++;
         end
      end
      n_checks++;
      if (bus.o_rptr !== model_rptr())
         $display("FAIL %s rptr: got %h, want %h",
                  name, bus.o_rptr, model_rptr());
      else n_pass++;
      clear_obs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int k = 0; k < 10; k++) mw[k] = '0;
      mfull = '0;
      bus.i_grant = 1'b1;
      pack();
      #1;
      n_checks++;
      if (bus.o_re !== 1'b0) $display("FAIL rst o_re: got %b want 0", bus.o_re);
      else n_pass++;
      n_checks++;
      if (bus.o_addr !== 14'd0) $display("FAIL rst o_addr: got %0d want 0", bus.o_addr);
      else n_pass++;
      n_checks++;
      if (bus.o_D !== 8'd0) $display("FAIL rst o_D: got %h want 0", bus.o_D);
      else n_pass++;
      n_checks++;
      if (bus.o_write !== 10'd0) $display("FAIL rst o_write: got %b want 0", bus.o_write);
      else n_pass++;
      n_checks++;
      if (bus.o_rptr !== 100'd0) $display("FAIL rst o_rptr: got %h want 0", bus.o_rptr);
      else n_pass++;
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      ram[2048] = 8'h5A;
      mw[2] = 10'd1;
      pack();
      @(negedge clk);
      n_checks++;
      if (bus.o_re !== 1'b1 || bus.o_addr !== 14'd2048)
         $display("FAIL single read: got re=%b addr=%0d, want re=1 addr=2048",
                  bus.o_re, bus.o_addr);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.o_re !== 1'b0) $display("FAIL single wait re: got %b want 0", bus.o_re);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.o_write !== 10'b0000000100 || bus.o_D !== 8'h5A)
         $display("FAIL single push: got w=%b d=%h, want w=0000000100 d=5a",
                  bus.o_write, bus.o_D);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.o_rptr[29:20] !== 10'd1 || bus.o_write !== 10'd0)
         $display("FAIL single after: got rptr2=%0d w=%b, want 1 and 0",
                  bus.o_rptr[29:20], bus.o_write);
      else n_pass++;
      run_batch("single", 1'b0, 10, 0);
   endtask

   task automatic test_round_robin();
      do_reset();
      mw[0] = 10'd2; mw[3] = 10'd2; mw[9] = 10'd2;
      pack();
      run_batch("round_robin", 1'b0, 100, 4);
   endtask

   task automatic test_backpressure();
      do_reset();
      mfull[3] = 1'b1;
      mw[1] = 10'd2; mw[3] = 10'd2; mw[5] = 10'd1;
      pack();
      run_batch("bp_skip", 1'b0, 100, 0);
      mfull[3] = 1'b0;
      pack();
      run_batch("bp_release", 1'b0, 100, 0);
   endtask

   task automatic test_grant_stall();
      do_reset();
      bus.i_grant = 1'b0;
      mw[4] = 10'd1;
      pack();
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.o_re !== 1'b1 || bus.o_addr !== 14'd4096 || bus.o_write !== 10'd0)
            $display("FAIL stall hold %0d: got re=%b addr=%0d w=%b, want 1 4096 0",
                     i, bus.o_re, bus.o_addr, bus.o_write);
         else n_pass++;
      end
      bus.i_grant = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.o_write !== 10'd0) $display("FAIL stall early: got w=%b want 0", bus.o_write);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.o_write !== 10'b0000010000)
         $display("FAIL stall push: got w=%b want 0000010000", bus.o_write);
      else n_pass++;
      run_batch("stall", 1'b0, 10, 0);
   endtask

   task automatic test_wrap();
      do_reset();
      mw[1] = 10'd1023;
      pack();
      run_batch("wrap_fill", 1'b0, 4400, 4);
      obs_a.delete();
      mw[1] = 10'd1;
      pack();
      run_batch("wrap", 1'b0, 50, 4);
      n_checks++;
      if (obs_a.size() != 2)
         $display("FAIL wrap reads: got %0d, want 2", obs_a.size());
      else if (obs_a[0] != 2047 || obs_a[1] != 1024)
         $display("FAIL wrap addr: got %0d,%0d want 2047,1024", obs_a[0], obs_a[1]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mw[6] = 10'd3;
      pack();
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.o_re !== 1'b0 || bus.o_addr !== 14'd0 ||
          bus.o_write !== 10'd0 || bus.o_D !== 8'd0)
         $display("FAIL midrst outputs: got re=%b addr=%0d w=%b d=%h, want all 0",
                  bus.o_re, bus.o_addr, bus.o_write, bus.o_D);
      else n_pass++;
      mw[6] = 10'd0;
      pack();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if (obs_w.size() != 0) $display("FAIL midrst pulses: got %0d want 0", obs_w.size());
      else n_pass++;
      n_checks++;
      if (bus.o_rptr !== 100'd0) $display("FAIL midrst rptr: got %h want 0", bus.o_rptr);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 10; k++) begin
            mw[k] = mw[k] + 10'($urandom_range(0, 4));
            mfull[k] = ($urandom_range(0, 3) == 0);
         end
         pack();
         run_batch("random", 1'b1, 800, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) ram[i] = 8'($urandom);
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_grant_stall();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
